coin_payout_sequencer: RTL and testbench
========================================

# coin_payout_sequencer

Sequences the vending machine's coin-return mechanism. It accepts payout requests from two requesters (refund path and change path), arbitrates between them, and pays each accepted amount one coin at a time from four coin tubes. Coins are chosen greedily, largest first, against tracked tube inventory, with a per-coin ejector handshake and jam timeout. It sits between the vending FSM and the physical ejector solenoids, and owns tube inventory.

## Interface
- EJECT_TIMEOUT, 15: cycles to wait for eject_ack before declaring the selected tube jammed (≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- ref_req  in  1  refund payout request, level; held by requester until ref_gnt
- ref_amt  in  8  refund amount in cents, sampled with grant
- chg_req  in  1  change payout request, level; held until chg_gnt
- chg_amt  in  8  change amount in cents, sampled with grant
- ref_gnt  out  1  one-cycle pulse: refund request accepted
- chg_gnt  out  1  one-cycle pulse: change request accepted
- restock  in  1  add coins to a tube (honoured in IDLE only)
- restock_sel  in  2  tube: 0 nickel, 1 dime, 2 quarter, 3 half-dollar
- restock_cnt  in  5  coins added, saturating at 31
- eject  out  1  one-cycle pulse: eject one coin from eject_sel tube
- eject_sel  out  2  tube being ejected, stable from eject until ack/timeout
- eject_ack  in  1  ejector confirms coin left tube
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at payout completion
- short  out  8  cents left unpaid by last payout, valid from done until next done
- fault  out  1  OR of the four tube jam flags
- nickel_cnt, dime_cnt, quarter_cnt, half_cnt  out  5 each  tube inventory

## Operation
- States: IDLE, SELECT, EJECT, WAIT_ACK, FINISH.
- IDLE: if ref_req, latch ref_amt into remaining and pulse ref_gnt; go to SELECT. Else if chg_req, same with chg_amt/chg_gnt. Refund wins a simultaneous request; the losing request stays pending and is granted on the next return to IDLE.
- SELECT: choose the largest denomination (50, 25, 10, 5) with value ≤ remaining, count > 0 and jam flag clear. If one is found, drive eject_sel and go to EJECT. Otherwise (remaining < 5, or no usable coin) go to FINISH.
- EJECT: eject=1 for exactly this cycle; clear the timer; go to WAIT_ACK.
- WAIT_ACK:
  - On eject_ack: decrement the tube count, subtract the denomination from remaining, go to SELECT.
  - Else if timer == EJECT_TIMEOUT−1: set that tube's jam flag, leave count and remaining unchanged, go to SELECT.
  - Else increment the timer.
- FINISH: done=1, short=remaining; go to IDLE.
- Amounts that are not multiples of 5 pay down to the residue; the residue (1–4) appears in short.
- Restock is applied only in IDLE: count = min(count+restock_cnt, 31), and that tube's jam flag is cleared. A restock in the same IDLE cycle as a grant is applied too; SELECT sees the updated count.
- eject_ack outside WAIT_ACK is ignored. A count never underflows, because a tube is selected only when its count > 0.
- remaining is 8-bit unsigned and never goes negative, because a denomination is selected only when its value ≤ remaining.

## Timing
- All outputs are registered. Reset values: every count 0, all jam flags clear, ref_gnt/chg_gnt/eject/done/busy/fault 0, eject_sel 0, short 0, state IDLE.
- Grant pulse is asserted in the cycle after the IDLE sampling edge, concurrent with the first SELECT cycle.
- Per coin: SELECT (1) + EJECT (1) + WAIT_ACK (≥1) cycles. With ack in the first WAIT_ACK cycle, 3 cycles per coin.
- Jammed coin costs 2 + EJECT_TIMEOUT cycles.
- Request to done: 1 + 3·coins + 1 cycles minimum. Zero amount: grant, SELECT, FINISH; done 2 cycles after sampling, short=0.
- rst mid-payout: return to reset values at the next edge; no done pulse; the in-flight request is lost, and the requester must re-request.

## Test plan
- Restock all tubes to 4; chg_req amt 85; ack 2 cycles after each eject → ejects half, quarter, dime; done; short=0; counts N4 D3 Q3 H3; chg_gnt one pulse.
- ref_req amt 30 and chg_req amt 50 in the same IDLE cycle (tubes full) → ref_gnt first; ejects quarter, nickel; done; then chg_gnt; ejects half; done.
- Quarters 0, dimes 2, nickels 1; chg amt 25 → ejects dime, dime, nickel; short=0; dimes 0, nickels 0.
- EJECT_TIMEOUT=15, halves 1, quarters 2; amt 50; no ack on half → after 15 WAIT_ACK cycles fault=1, half_cnt stays 1; two quarters ejected; short=0. Then restock half → fault=0.
- Only nickels=2; amt 40 → two nickels; short=30. Separately, amt 7 → one nickel; short=2.
- Assert rst during WAIT_ACK → next cycle all outputs at reset values, no done, counts 0.

Source files
------------

// File: rtl/coin_payout_sequencer_if.sv
// Requester, restock, ejector and status signals of the coin payout sequencer.
// The sequencer uses the slave modport; the requester/ejector side uses master.
interface coin_payout_sequencer_if;
    localparam int unsigned AMT_W = 8;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 5;

    logic             ref_req;
    logic [AMT_W-1:0] ref_amt;
    logic             chg_req;
    logic [AMT_W-1:0] chg_amt;
    logic             ref_gnt;
    logic             chg_gnt;

    logic             restock;
    logic [SEL_W-1:0] restock_sel;
    logic [CNT_W-1:0] restock_cnt;

    logic             eject;
    logic [SEL_W-1:0] eject_sel;
    logic             eject_ack;

    logic             busy;
    logic             done;
    logic [AMT_W-1:0] short;
    logic             fault;
    logic [CNT_W-1:0] nickel_cnt;
    logic [CNT_W-1:0] dime_cnt;
    logic [CNT_W-1:0] quarter_cnt;
    logic [CNT_W-1:0] half_cnt;

    modport master (
        output ref_req, ref_amt, chg_req, chg_amt,
        output restock, restock_sel, restock_cnt,
        output eject_ack,
        input  ref_gnt, chg_gnt,
        input  eject, eject_sel,
        input  busy, done, short, fault,
        input  nickel_cnt, dime_cnt, quarter_cnt, half_cnt
    );

    modport slave (
        input  ref_req, ref_amt, chg_req, chg_amt,
        input  restock, restock_sel, restock_cnt,
        input  eject_ack,
        output ref_gnt, chg_gnt,
        output eject, eject_sel,
        output busy, done, short, fault,
        output nickel_cnt, dime_cnt, quarter_cnt, half_cnt
    );
endinterface

// File: rtl/coin_payout_sequencer.sv
// Arbitrates refund/change payouts and pays each amount coin by coin, largest
// usable denomination first, tracking tube inventory and per-tube jam flags.
module coin_payout_sequencer #(
    parameter int unsigned EJECT_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    coin_payout_sequencer_if.slave  bus
);
    localparam int unsigned AMT_W = 8;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned NTUBE = 4;
    localparam int unsigned TMR_W = (EJECT_TIMEOUT > 2) ? $clog2(EJECT_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(EJECT_TIMEOUT - 1);

    localparam logic [SEL_W-1:0] T_NICKEL  = 2'd0;
    localparam logic [SEL_W-1:0] T_DIME    = 2'd1;
    localparam logic [SEL_W-1:0] T_QUARTER = 2'd2;
    localparam logic [SEL_W-1:0] T_HALF    = 2'd3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_EJECT    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_FINISH   = 3'd4;

    // Face value in cents of the coin held in a tube.
    function automatic logic [AMT_W-1:0] coin_value(input logic [SEL_W-1:0] tube);
        logic [AMT_W-1:0] v;
        case (tube)
            T_NICKEL:  v = 8'd5;
            T_DIME:    v = 8'd10;
            T_QUARTER: v = 8'd25;
            default:   v = 8'd50;
        endcase
        return v;
    endfunction

    logic [2:0]       state, state_nxt;
    logic [AMT_W-1:0] remaining, remaining_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] cnt     [NTUBE];
    logic [CNT_W-1:0] cnt_nxt [NTUBE];
    logic [NTUBE-1:0] jam, jam_nxt;

    logic             ref_gnt_q, ref_gnt_nxt;
    logic             chg_gnt_q, chg_gnt_nxt;
    logic             eject_q, eject_nxt;
    logic [SEL_W-1:0] eject_sel_q, eject_sel_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [AMT_W-1:0] short_q, short_nxt;
    logic             fault_q, fault_nxt;

    logic [CNT_W:0]   rs_sum;
    logic [CNT_W-1:0] rs_sat;
    logic [NTUBE-1:0] usable;
    logic             pick_ok;
    logic [SEL_W-1:0] pick_sel;

    // Saturating restock of the addressed tube.
    assign rs_sum = (CNT_W+1)'(cnt[bus.restock_sel]) + (CNT_W+1)'(bus.restock_cnt);
    assign rs_sat = rs_sum[CNT_W] ? CNT_MAX : rs_sum[CNT_W-1:0];

    // A tube is usable when its coin fits, it holds coins and it is not jammed.
    assign usable[T_NICKEL]  = (coin_value(T_NICKEL)  <= remaining) && (cnt[T_NICKEL]  != '0) && !jam[T_NICKEL];
    assign usable[T_DIME]    = (coin_value(T_DIME)    <= remaining) && (cnt[T_DIME]    != '0) && !jam[T_DIME];
    assign usable[T_QUARTER] = (coin_value(T_QUARTER) <= remaining) && (cnt[T_QUARTER] != '0) && !jam[T_QUARTER];
    assign usable[T_HALF]    = (coin_value(T_HALF)    <= remaining) && (cnt[T_HALF]    != '0) && !jam[T_HALF];

    // Greedy choice: largest usable denomination wins.
    always_comb begin
        pick_ok  = |usable;
        pick_sel = T_NICKEL;
        if (usable[T_HALF]) begin
            pick_sel = T_HALF;
        end else if (usable[T_QUARTER]) begin
            pick_sel = T_QUARTER;
        end else if (usable[T_DIME]) begin
            pick_sel = T_DIME;
        end
    end

    // Next-state and next-output logic; outputs are registered from *_nxt.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        timer_nxt     = timer;
        cnt_nxt       = cnt;
        jam_nxt       = jam;
        ref_gnt_nxt   = 1'b0;
        chg_gnt_nxt   = 1'b0;
        eject_nxt     = 1'b0;
        eject_sel_nxt = eject_sel_q;
        done_nxt      = 1'b0;
        short_nxt     = short_q;

        case (state)
            S_IDLE: begin
                if (bus.restock) begin
                    cnt_nxt[bus.restock_sel] = rs_sat;
                    jam_nxt[bus.restock_sel] = 1'b0;
                end
                if (bus.ref_req) begin
                    remaining_nxt = bus.ref_amt;
                    ref_gnt_nxt   = 1'b1;
                    state_nxt     = S_SELECT;
                end else if (bus.chg_req) begin
                    remaining_nxt = bus.chg_amt;
                    chg_gnt_nxt   = 1'b1;
                    state_nxt     = S_SELECT;
                end
            end

            S_SELECT: begin
                if (pick_ok) begin
                    eject_sel_nxt = pick_sel;
                    eject_nxt     = 1'b1;
                    state_nxt     = S_EJECT;
                end else begin
                    done_nxt  = 1'b1;
                    short_nxt = remaining;
                    state_nxt = S_FINISH;
                end
            end

            S_EJECT: begin
                timer_nxt = '0;
                state_nxt = S_WAIT_ACK;
            end

            // Ack beats timeout when both land in the same cycle.
            S_WAIT_ACK: begin
                if (bus.eject_ack) begin
                    cnt_nxt[eject_sel_q] = cnt[eject_sel_q] - 1'b1;
                    remaining_nxt        = remaining - coin_value(eject_sel_q);
                    state_nxt            = S_SELECT;
                end else if (timer == TMR_LAST) begin
                    jam_nxt[eject_sel_q] = 1'b1;
                    state_nxt            = S_SELECT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            S_FINISH: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt  = (state_nxt != S_IDLE);
        fault_nxt = |jam_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            remaining   <= '0;
            timer       <= '0;
            cnt         <= '{default: '0};
            jam         <= '0;
            ref_gnt_q   <= 1'b0;
            chg_gnt_q   <= 1'b0;
            eject_q     <= 1'b0;
            eject_sel_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            remaining   <= remaining_nxt;
            timer       <= timer_nxt;
            cnt         <= cnt_nxt;
            jam         <= jam_nxt;
            ref_gnt_q   <= ref_gnt_nxt;
            chg_gnt_q   <= chg_gnt_nxt;
            eject_q     <= eject_nxt;
            eject_sel_q <= eject_sel_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            short_q     <= short_nxt;
            fault_q     <= fault_nxt;
        end
    end

    assign bus.ref_gnt     = ref_gnt_q;
    assign bus.chg_gnt     = chg_gnt_q;
    assign bus.eject       = eject_q;
    assign bus.eject_sel   = eject_sel_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.short       = short_q;
    assign bus.fault       = fault_q;
    assign bus.nickel_cnt  = cnt[T_NICKEL];
    assign bus.dime_cnt    = cnt[T_DIME];
    assign bus.quarter_cnt = cnt[T_QUARTER];
    assign bus.half_cnt    = cnt[T_HALF];

endmodule

// File: tb/tb_coin_payout_sequencer.sv
// Bench for coin_payout_sequencer: directed payout scenarios plus randomized
// traffic, all compared against a transaction-level inventory/payout model.
module tb_coin_payout_sequencer;
    localparam int unsigned T = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coin_payout_sequencer_if bus();

    coin_payout_sequencer #(.EJECT_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: inventory, jam flags and the payout in progress.
    int       val [4] = '{5, 10, 25, 50};
    int       m_cnt [4];
    bit [3:0] m_jam;
    int       m_rem;
    bit       m_active;
    int       m_cyc;
    int       m_lat;
    bit       prev_idle;

    // Ejector emulation: one eject episode at a time.
    bit       ep_on;
    int       ep_w;
    int       ep_ack_at;
    int       ep_sel;
    bit       ack_drop;

    int       ack_fixed;
    bit [3:0] jam_force;
    bit       chaos;

    logic [15:0] ej_log;
    int          ej_n;
    int          ref_gnts;
    int          chg_gnts;
    logic [7:0]  gnt_order;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Largest denomination that fits, is stocked and not jammed; 4 = none.
    function automatic int pick();
        for (int d = 3; d >= 0; d--) begin
            if (val[d] <= m_rem && m_cnt[d] > 0 && !m_jam[d]) return d;
        end
        return 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_inv();
        check("nickel_cnt",  bus.nickel_cnt,  m_cnt[0]);
        check("dime_cnt",    bus.dime_cnt,    m_cnt[1]);
        check("quarter_cnt", bus.quarter_cnt, m_cnt[2]);
        check("half_cnt",    bus.half_cnt,    m_cnt[3]);
        check("fault",       bus.fault,       |m_jam);
    endtask

    // One clock: consume last cycle's inputs in the model, check outputs, drive the ejector.
    task automatic cycle();
        logic       pr, pc, prs;
        logic [1:0] psel;
        logic [4:0] pcnt;
        logic [7:0] ramt, camt;
        bit         exp_r, exp_c, exp_done;
        int         r;
        pr = bus.ref_req;  pc = bus.chg_req;  prs = bus.restock;
        psel = bus.restock_sel;  pcnt = bus.restock_cnt;
        ramt = bus.ref_amt;  camt = bus.chg_amt;
        tick();
        if (ack_drop) begin
            bus.eject_ack = 1'b0;
            ack_drop = 1'b0;
        end
        bus.restock = 1'b0;

        if (prev_idle && prs) begin
            m_cnt[psel] = (m_cnt[psel] + int'(pcnt) > 31) ? 31 : m_cnt[psel] + int'(pcnt);
            m_jam[psel] = 1'b0;
        end
        exp_r = prev_idle && pr;
        exp_c = prev_idle && !pr && pc;
        check("ref_gnt", bus.ref_gnt, exp_r);
        check("chg_gnt", bus.chg_gnt, exp_c);
        if (bus.ref_gnt) ref_gnts++;
        if (bus.chg_gnt) chg_gnts++;
        if (exp_r || exp_c) begin
            m_active = 1'b1;
            m_rem = exp_r ? int'(ramt) : int'(camt);
            m_cyc = 0;
            m_lat = 0;
            gnt_order = {gnt_order[6:0], exp_c};
            if (exp_r) bus.ref_req = 1'b0;
            else       bus.chg_req = 1'b0;
        end else if (m_active) begin
            m_cyc++;
        end
        check("busy", bus.busy, m_active);
        prev_idle = !m_active;

        if (ep_on) begin
            ep_w++;
            check("eject_pulse", bus.eject, 0);
            check("eject_sel_hold", bus.eject_sel, ep_sel);
            if (ep_ack_at == ep_w) begin
                bus.eject_ack = 1'b1;
                ack_drop = 1'b1;
                m_cnt[ep_sel]--;
                m_rem -= val[ep_sel];
                m_lat += 2 + ep_w;
                ep_on = 1'b0;
            end else if (ep_ack_at == 0 && ep_w == int'(T)) begin
                m_jam[ep_sel] = 1'b1;
                m_lat += 2 + int'(T);
                ep_on = 1'b0;
            end else if (chaos && ep_w == 1 && $urandom_range(0, 3) == 0) begin
                bus.restock = 1'b1;
                bus.restock_sel = 2'($urandom_range(0, 3));
                bus.restock_cnt = 5'($urandom_range(1, 31));
            end
        end else if (bus.eject) begin
            check("eject_sel", bus.eject_sel, m_active ? pick() : 4);
            ep_on = 1'b1;
            ep_w = 0;
            ep_sel = int'(bus.eject_sel);
            ej_log = {ej_log[13:0], bus.eject_sel};
            ej_n++;
            if (jam_force[ep_sel]) begin
                ep_ack_at = 0;
            end else if (ack_fixed != 0) begin
                ep_ack_at = ack_fixed;
            end else begin
                r = int'($urandom_range(0, 9));
                ep_ack_at = (r == 0) ? 0 : (r == 1) ? int'(T) : 1 + int'($urandom_range(0, 2));
            end
        end

        exp_done = m_active && !ep_on && pick() == 4 && m_cyc == m_lat + 1;
        check("done", bus.done, exp_done);
        if (exp_done) begin
            check("short", bus.short, m_rem);
            check_inv();
            m_active = 1'b0;
        end

        if (chaos && prev_idle && !ack_drop && $urandom_range(0, 3) == 0) begin
            bus.eject_ack = 1'b1;
            ack_drop = 1'b1;
        end
    endtask

    task automatic service(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while ((m_active || bus.ref_req || bus.chg_req || ep_on) && n < budget);
        check("service_idle", {m_active, bus.ref_req, bus.chg_req, ep_on}, 0);
    endtask

    task automatic restock_tube(input int sel, input int cnt);
        if (!prev_idle) cycle();
        bus.restock = 1'b1;
        bus.restock_sel = 2'(sel);
        bus.restock_cnt = 5'(cnt);
        cycle();
        check_inv();
    endtask

    task automatic payout(input bit r, input int ra, input bit c, input int ca);
        if (!prev_idle) cycle();
        bus.ref_req = r;
        bus.ref_amt = 8'(ra);
        bus.chg_req = c;
        bus.chg_amt = 8'(ca);
        service(1500);
    endtask

    task automatic clear_logs();
        ej_log = '0;  ej_n = 0;  ref_gnts = 0;  chg_gnts = 0;  gnt_order = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ref_req = 1'b0;  bus.chg_req = 1'b0;  bus.ref_amt = '0;  bus.chg_amt = '0;
        bus.restock = 1'b0;  bus.restock_sel = '0;  bus.restock_cnt = '0;  bus.eject_ack = 1'b0;
        tick();
        check("rst_outs", {bus.ref_gnt, bus.chg_gnt, bus.eject, bus.eject_sel, bus.busy,
                           bus.done, bus.short, bus.fault}, 0);
        check("rst_cnts", {bus.nickel_cnt, bus.dime_cnt, bus.quarter_cnt, bus.half_cnt}, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_jam = '0;  m_rem = 0;  m_active = 1'b0;  m_cyc = 0;  m_lat = 0;  prev_idle = 1'b1;
        ep_on = 1'b0;  ep_w = 0;  ack_drop = 1'b0;
        ack_fixed = 0;  jam_force = '0;  chaos = 1'b0;
        clear_logs();
    endtask

    initial begin
        int n;
        int mode;

        // Greedy 85c from four of each, ack two cycles after eject.
        do_reset();
        for (int i = 0; i < 4; i++) restock_tube(i, 4);
        ack_fixed = 2;
        clear_logs();
        payout(1'b0, 0, 1'b1, 85);
        check("t1_seq", ej_log, 16'h0039);
        check("t1_n", ej_n, 3);
        check("t1_short", bus.short, 0);
        check("t1_cnts", {bus.nickel_cnt, bus.dime_cnt, bus.quarter_cnt, bus.half_cnt},
              {5'd4, 5'd3, 5'd3, 5'd3});
        check("t1_chg_gnts", chg_gnts, 1);

        // Simultaneous requests with full tubes; restock saturates at 31.
        do_reset();
        for (int i = 0; i < 4; i++) restock_tube(i, 31);
        restock_tube(0, 5);
        check("t2_sat", bus.nickel_cnt, 31);
        ack_fixed = 1;
        clear_logs();
        payout(1'b1, 30, 1'b1, 50);
        check("t2_order", gnt_order, 8'h01);
        check("t2_seq", ej_log, 16'h0023);
        check("t2_short", bus.short, 0);

        // No quarters: 25c from dimes and a nickel.
        do_reset();
        restock_tube(1, 2);
        restock_tube(0, 1);
        ack_fixed = 1;
        clear_logs();
        payout(1'b0, 0, 1'b1, 25);
        check("t3_seq", ej_log, 16'h0014);
        check("t3_short", bus.short, 0);
        check("t3_cnts", {bus.nickel_cnt, bus.dime_cnt}, 0);

        // Half-dollar jams; payout falls back to quarters; restock clears the jam.
        do_reset();
        restock_tube(3, 1);
        restock_tube(2, 2);
        ack_fixed = 1;
        jam_force = 4'b1000;
        clear_logs();
        payout(1'b1, 50, 1'b0, 0);
        check("t4_seq", ej_log, 16'h003A);
        check("t4_fault", bus.fault, 1);
        check("t4_half", bus.half_cnt, 1);
        check("t4_short", bus.short, 0);
        jam_force = '0;
        restock_tube(3, 1);
        check("t4_fault_clr", bus.fault, 0);

        // Shortfall and non-multiple-of-five residue.
        do_reset();
        restock_tube(0, 2);
        ack_fixed = 1;
        payout(1'b0, 0, 1'b1, 40);
        check("t5_short40", bus.short, 30);
        restock_tube(0, 1);
        clear_logs();
        payout(1'b1, 7, 1'b0, 0);
        check("t5_short7", bus.short, 2);
        check("t5_n7", ej_n, 1);
        payout(1'b1, 0, 1'b0, 0);
        check("t5_zero", bus.short, 0);

        // Reset while waiting for an ack drops the payout without done.
        do_reset();
        restock_tube(2, 3);
        jam_force = 4'b0100;
        bus.chg_req = 1'b1;
        bus.chg_amt = 8'd25;
        n = 0;
        while (!(ep_on && ep_w == 2) && n < 30) begin
            cycle();
            n++;
        end
        check("t6_in_wait", {ep_on, ep_w == 2}, 2'b11);
        do_reset();
        repeat (4) cycle();

        // Randomized traffic with jams, late acks, stray acks and restocks.
        do_reset();
        chaos = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) restock_tube(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)));
            mode = int'($urandom_range(0, 2));
            if (!prev_idle) cycle();
            if ($urandom_range(0, 2) == 0) begin
                bus.restock = 1'b1;
                bus.restock_sel = 2'($urandom_range(0, 3));
                bus.restock_cnt = 5'($urandom_range(0, 31));
            end
            payout(mode != 1, int'($urandom_range(0, 160)), mode != 0, int'($urandom_range(0, 160)));
        end
        check_inv();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
